// File: rtl/vol_pkg.sv
// Shared constants, FSM encoding and the attenuation step helper for vol_adjust.
package vol_pkg;

    localparam logic [7:0] VOL_STEP    = 8'h10;
    localparam logic [7:0] VOL_ATT_MIN = 8'h00;
    localparam logic [7:0] VOL_ATT_MAX = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } vol_state_e;

    // Saturating one-step move; up means louder (less attenuation).
    function automatic logic [7:0] att_next(input logic [7:0] att, input logic up,
                                            input logic down);
        logic [7:0] res;
        res = att;
        if (up && !down) begin
            res = (att == VOL_ATT_MIN) ? att : att - VOL_STEP;
        end else if (down && !up) begin
            res = (att == VOL_ATT_MAX) ? att : att + VOL_STEP;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises, debounces and edge-detects one raw button, with hold-to-repeat events.
module btn_debounce
    import vol_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned REPEAT_CYC   = 25_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic level,
    output logic evt
);

    localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned RpW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);
    localparam logic [RpW-1:0] RpLast = RpW'(REPEAT_CYC - 1);

    logic [1:0]     sync_q;
    logic           level_q, level_d;
    logic           evt_q, evt_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic [RpW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic           synced;

    assign synced = sync_q[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= 2'b00;
            level_q   <= 1'b0;
            evt_q     <= 1'b0;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw};
            level_q   <= level_d;
            evt_q     <= evt_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        // Level flips on the DEBOUNCE_CYC-th consecutive cycle of disagreement.
        if (synced != level_q) begin
            if (db_cnt_q == DbLast) begin
                level_d = synced;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        evt_d     = 1'b0;
        rpt_cnt_d = '0;
        if (level_d && !level_q) begin
            evt_d = 1'b1;
        end else if (level_d && level_q) begin
            if (rpt_cnt_q == RpLast) begin
                evt_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign evt   = evt_q;

endmodule

// File: rtl/vol_adjust.sv
// Volume button front end: arbitrates button events into an attenuation value and
// offers each new {att,att} SCI_VOL word to the SCI writer over a req/ack handshake.
module vol_adjust
    import vol_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned REPEAT_CYC   = 25_000_000,
    parameter logic [7:0]  VOL_INIT     = 8'h40
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [15:0] vol,
    output logic        vol_wr_req,
    input  logic        vol_wr_ack
);

    logic up_lvl, up_evt, dn_lvl, dn_evt;
    logic up_go, dn_go;

    vol_state_e  state_q, state_d;
    logic [7:0]  att_q, att_d;
    logic [15:0] vol_q, vol_d;
    logic        req_q, req_d;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REPEAT_CYC  (REPEAT_CYC)
    ) u_btn_up (
        .CLK    (CLK),
        .RST    (RST),
        .btn_raw(btn_up),
        .level  (up_lvl),
        .evt    (up_evt)
    );

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REPEAT_CYC  (REPEAT_CYC)
    ) u_btn_down (
        .CLK    (CLK),
        .RST    (RST),
        .btn_raw(btn_down),
        .level  (dn_lvl),
        .evt    (dn_evt)
    );

    // Both held suppresses everything; coincident pulses cancel.
    assign up_go = up_evt && !dn_evt && !(up_lvl && dn_lvl);
    assign dn_go = dn_evt && !up_evt && !(up_lvl && dn_lvl);
    assign att_d = att_next(att_q, up_go, dn_go);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_REQ;
            att_q   <= VOL_INIT;
            vol_q   <= {VOL_INIT, VOL_INIT};
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            att_q   <= att_d;
            vol_q   <= vol_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vol_d   = vol_q;
        req_d   = req_q;
        unique case (state_q)
            S_IDLE: begin
                req_d = 1'b0;
                if (att_q != vol_q[7:0]) begin
                    vol_d   = {att_q, att_q};
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // req_q is low only on the first cycle after reset; no ack is owed yet.
                req_d = 1'b1;
                if (vol_wr_ack && req_q) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign vol        = vol_q;
    assign vol_wr_req = req_q;

endmodule

// File: tb/tb_vol_adjust.sv
// Self-checking bench for vol_adjust: directed scenarios plus randomized presses
// compared against a press-level attenuation model.
module tb_vol_adjust;

    localparam int unsigned DB   = 4;
    localparam int unsigned RP   = 16;
    localparam logic [7:0]  INIT = 8'h40;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        vol_wr_ack = 1'b0;
    logic [15:0] vol;
    logic        vol_wr_req;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_att;

    vol_adjust #(
        .DEBOUNCE_CYC(DB),
        .REPEAT_CYC  (RP),
        .VOL_INIT    (INIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .vol       (vol),
        .vol_wr_req(vol_wr_req),
        .vol_wr_ack(vol_wr_ack)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] a, input bit up);
        if (up) return (a == 8'h00) ? 8'h00 : a - 8'h10;
        return (a == 8'hF0) ? 8'hF0 : a + 8'h10;
    endfunction

    // A clean hold of h sampled cycles yields one press event plus one per full repeat period.
    function automatic int events_for_hold(input int h);
        if (h < int'(DB)) return 0;
        return (h + int'(RP) - 1) / int'(RP);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One press of a single button with randomized ack delay; checks the resulting writes.
    task automatic press_step(input string tag, input bit up, input int hold);
        logic [7:0]  prev;
        logic [15:0] seen_vol;
        int          nreq;
        int          wait_c;
        bit          in_req;
        bit          stable;
        prev = m_att;
        for (int k = 0; k < events_for_hold(hold); k++) m_att = model_step(m_att, up);
        nreq = 0;
        in_req = 0;
        stable = 1;
        wait_c = 0;
        seen_vol = vol;
        if (up) btn_up = 1'b1;
        else btn_down = 1'b1;
        for (int c = 0; c < hold + 30; c++) begin
            tick();
            if (c == hold - 1) begin
                btn_up = 1'b0;
                btn_down = 1'b0;
            end
            vol_wr_ack = 1'b0;
            if (vol_wr_req && !in_req) begin
                nreq++;
                seen_vol = vol;
                in_req = 1;
                wait_c = $urandom_range(0, 3);
            end
            if (in_req) begin
                if (vol !== seen_vol) stable = 0;
                if (wait_c == 0) begin
                    vol_wr_ack = 1'b1;
                    in_req = 0;
                end else begin
                    wait_c--;
                end
            end
        end
        vol_wr_ack = 1'b0;
        check({tag, "_nreq"}, nreq, (m_att != prev) ? 1 : 0);
        if (m_att != prev) begin
            check({tag, "_vol"}, seen_vol, {m_att, m_att});
            check({tag, "_stable"}, stable, 1);
        end
        check({tag, "_final"}, vol, {m_att, m_att});
    endtask

    initial begin
        int          nreq;
        int          first_c;
        bit          stable;
        logic [15:0] vol_before;

        m_att = INIT;

        // 1. reset write
        repeat (3) tick();
        check("rst_req", vol_wr_req, 0);
        check("rst_vol", vol, 16'h4040);
        RST = 1'b0;
        tick();
        check("init_req", vol_wr_req, 1);
        check("init_vol", vol, 16'h4040);
        vol_wr_ack = 1'b1;
        tick();
        vol_wr_ack = 1'b0;
        check("init_ack_req", vol_wr_req, 0);
        nreq = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (vol_wr_req) nreq++;
        end
        check("idle_noreq", nreq, 0);

        // 2. glitch rejected, then a clean 10-cycle hold
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        nreq = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (vol_wr_req) nreq++;
        end
        check("glitch_noreq", nreq, 0);
        check("glitch_vol", vol, 16'h4040);

        m_att = model_step(m_att, 1'b1);
        btn_up = 1'b1;
        nreq = 0;
        first_c = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 9) btn_up = 1'b0;
            vol_wr_ack = 1'b0;
            if (vol_wr_req) begin
                if (first_c < 0) begin
                    first_c = c;
                    check("up10_vol", vol, 16'h3030);
                end
                nreq++;
                vol_wr_ack = 1'b1;
            end
        end
        vol_wr_ack = 1'b0;
        check("up10_nreq", nreq, 1);
        // 2 sync + DB stable cycles to the press event, then n+2 to req.
        check("up10_latency", first_c, 7);

        // 3. saturation at both ends
        for (int i = 0; i < 4; i++) press_step("sat_up", 1'b1, 6);
        check("sat_up_min", vol, 16'h0000);
        for (int i = 0; i < 16; i++) press_step("sat_dn", 1'b0, 6);
        check("sat_dn_max", vol, 16'hF0F0);
        for (int i = 0; i < 11; i++) press_step("to40", 1'b1, 6);

        // 4. held down with ack withheld: coalesced write after ack
        for (int k = 0; k < events_for_hold(46); k++) m_att = model_step(m_att, 1'b0);
        btn_down = 1'b1;
        stable = 1;
        for (int c = 0; c < 66; c++) begin
            tick();
            if (c == 45) btn_down = 1'b0;
            if (vol_wr_req && vol !== 16'h5050) stable = 0;
        end
        check("hold_req_high", vol_wr_req, 1);
        check("hold_vol_held", stable, 1);
        check("hold_vol", vol, 16'h5050);
        vol_wr_ack = 1'b1;
        tick();
        vol_wr_ack = 1'b0;
        check("hold_done_req", vol_wr_req, 0);
        tick();
        check("hold_idle_req", vol_wr_req, 0);
        tick();
        check("hold_coal_req", vol_wr_req, 1);
        check("hold_coal_vol", vol, {m_att, m_att});
        check("hold_coal_7070", vol, 16'h7070);
        vol_wr_ack = 1'b1;
        tick();
        vol_wr_ack = 1'b0;
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vol_wr_req) nreq++;
        end
        check("hold_single_write", nreq, 0);

        // 5. both buttons held: nothing happens
        vol_before = vol;
        btn_up = 1'b1;
        btn_down = 1'b1;
        nreq = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (c == 39) begin
                btn_up = 1'b0;
                btn_down = 1'b0;
            end
            if (vol_wr_req) nreq++;
        end
        check("both_noreq", nreq, 0);
        check("both_vol", vol, vol_before);

        // 6. reset mid-handshake
        m_att = model_step(m_att, 1'b1);
        btn_up = 1'b1;
        first_c = -1;
        for (int c = 0; c < 30 && first_c < 0; c++) begin
            tick();
            if (c == 5) btn_up = 1'b0;
            if (vol_wr_req) first_c = c;
        end
        btn_up = 1'b0;
        check("mid_req_seen", (first_c >= 0) ? 1 : 0, 1);
        check("mid_vol", vol, 16'h6060);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_req", vol_wr_req, 0);
        check("mid_rst_vol", vol, 16'h4040);
        m_att = INIT;
        repeat (8) tick();
        check("mid_rewrite_req", vol_wr_req, 1);
        check("mid_rewrite_vol", vol, 16'h4040);
        vol_wr_ack = 1'b1;
        tick();
        vol_wr_ack = 1'b0;
        check("mid_rewrite_ack", vol_wr_req, 0);
        repeat (10) tick();

        // random single presses against the model
        for (int i = 0; i < 24; i++) begin
            press_step("rand", 1'($urandom_range(0, 1)), $urandom_range(DB + 1, 12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
